// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle control sequencer.
// Holds opcode values, the FSM state encoding, the instruction class used
// between decoder and sequencer, and the code constants that drive the
// datapath selects (ALUOp, PCSrc, RegDst, ExtSel).
package mc_pkg;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    // Instruction class as seen by the sequencer
    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_BR   = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_HALT = 3'd6
    } ins_class_t;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // Next-PC source
    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_RS   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP = 2'b11;

    // Destination register select
    localparam logic [1:0] REGDST_R31 = 2'b00;
    localparam logic [1:0] REGDST_RT  = 2'b01;
    localparam logic [1:0] REGDST_RD  = 2'b10;

    // Immediate extension mode
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_SHAMT = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode decoder.
// Produces the selects that depend only on the opcode (they hold the same
// value in every sequencer state), an illegal-opcode flag and the
// instruction class that steers the sequencer.
// Ports:
//   op          in   opcode from IR
//   alu_op      out  ALU operation code
//   alu_src_a   out  ALU A select (1 = shamt)
//   alu_src_b   out  ALU B select (1 = extended immediate)
//   ext_sel     out  immediate extension mode
//   reg_dst     out  destination register select
//   db_data_src out  DBDR source (1 = data memory)
//   is_illegal  out  opcode not in the supported set
//   ins_class   out  instruction class
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  op,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  ext_sel,
    output logic [1:0]  reg_dst,
    output logic        db_data_src,
    output logic        is_illegal,
    output ins_class_t  ins_class
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        ext_sel     = EXT_ZERO;
        reg_dst     = REGDST_R31;
        db_data_src = 1'b0;
        is_illegal  = 1'b0;
        ins_class   = CLS_R;
        case (op)
            OP_ADD: begin
                reg_dst = REGDST_RD;
            end
            OP_SUB: begin
                alu_op  = ALU_SUB;
                reg_dst = REGDST_RD;
            end
            OP_OR: begin
                alu_op  = ALU_OR;
                reg_dst = REGDST_RD;
            end
            OP_AND: begin
                alu_op  = ALU_AND;
                reg_dst = REGDST_RD;
            end
            OP_SLL: begin
                alu_op    = ALU_SLL;
                alu_src_a = 1'b1;
                ext_sel   = EXT_SHAMT;
                reg_dst   = REGDST_RD;
            end
            OP_SLT: begin
                alu_op  = ALU_SLT;
                reg_dst = REGDST_RD;
            end
            OP_ADDI: begin
                alu_src_b = 1'b1;
                ext_sel   = EXT_SIGN;
                reg_dst   = REGDST_RT;
                ins_class = CLS_I;
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
                reg_dst   = REGDST_RT;
                ins_class = CLS_I;
            end
            OP_LW: begin
                alu_src_b   = 1'b1;
                ext_sel     = EXT_SIGN;
                reg_dst     = REGDST_RT;
                db_data_src = 1'b1;
                ins_class   = CLS_LD;
            end
            OP_SW: begin
                alu_src_b = 1'b1;
                ext_sel   = EXT_SIGN;
                ins_class = CLS_ST;
            end
            OP_BEQ, OP_BNE: begin
                // Branches compare rs and rt by subtraction; the immediate
                // only feeds the PC adder, so ALU B stays on BDR.
                alu_op    = ALU_SUB;
                ext_sel   = EXT_SIGN;
                ins_class = CLS_BR;
            end
            OP_J, OP_JR: begin
                ins_class = CLS_JMP;
            end
            OP_JAL: begin
                reg_dst   = REGDST_R31;
                ins_class = CLS_JMP;
            end
            OP_HALT: begin
                ins_class = CLS_HALT;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control sequencer for the MIPS-subset datapath.
// Steps each instruction through IF/ID/EXE/MEM/WB, stalls IF and MEM on
// mem_ready, and keeps a halt state, a sticky illegal-opcode flag and a
// retired-instruction counter.
// Ports:
//   CLK, RST   clock; synchronous active-high reset
//   op         opcode from IR
//   zero       ALU zero flag, used in EXE of branches
//   mem_ready  memory access complete (used only in IF and MEM)
//   PCWre, InsMemRW, IRWre, RegWre, WrRegData, DataMemRW  strobes
//   ALUSrcA, ALUSrcB, DBDataSrc, ExtSel, RegDst, ALUOp    decode selects
//   PCSrc      next-PC source
//   halted     sequencer is in HALT
//   illegal    sticky unknown-opcode flag
//   InsCount   retired-instruction count (wraps)
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWre,
    output logic             InsMemRW,
    output logic             IRWre,
    output logic             RegWre,
    output logic             WrRegData,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             DataMemRW,
    output logic             DBDataSrc,
    output logic [1:0]       ExtSel,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] InsCount
);

    state_t           state, state_nxt;
    ins_class_t       ins_class;
    logic             is_illegal;
    logic             pc_wre, ir_wre, reg_wre, wr_reg_data, dmem_rw;
    logic [1:0]       pc_src;
    logic             set_illegal, enter_halt, branch_taken;
    logic             illegal_q;
    logic [CNT_W-1:0] ins_count;

    mc_decode u_decode (
        .op          (op),
        .alu_op      (ALUOp),
        .alu_src_a   (ALUSrcA),
        .alu_src_b   (ALUSrcB),
        .ext_sel     (ExtSel),
        .reg_dst     (RegDst),
        .db_data_src (DBDataSrc),
        .is_illegal  (is_illegal),
        .ins_class   (ins_class)
    );

    assign branch_taken = (op == OP_BNE) ? ~zero : zero;

    always_comb begin
        state_nxt   = state;
        pc_wre      = 1'b0;
        ir_wre      = 1'b0;
        reg_wre     = 1'b0;
        wr_reg_data = 1'b0;
        dmem_rw     = 1'b0;
        pc_src      = PCSRC_PC4;
        set_illegal = 1'b0;
        enter_halt  = 1'b0;
        case (state)
            S_IF: begin
                ir_wre = mem_ready;
                if (mem_ready) state_nxt = S_ID;
            end
            S_ID: begin
                if (is_illegal) begin
                    // Unknown opcodes retire as a nop: step PC, flag it.
                    pc_wre      = 1'b1;
                    set_illegal = 1'b1;
                    state_nxt   = S_IF;
                end else begin
                    case (ins_class)
                        CLS_JMP: begin
                            pc_wre    = 1'b1;
                            pc_src    = (op == OP_JR) ? PCSRC_RS : PCSRC_JUMP;
                            reg_wre   = (op == OP_JAL);
                            state_nxt = S_IF;
                        end
                        CLS_HALT: begin
                            enter_halt = 1'b1;
                            state_nxt  = S_HALT;
                        end
                        default: state_nxt = S_EXE;
                    endcase
                end
            end
            S_EXE: begin
                case (ins_class)
                    CLS_BR: begin
                        pc_wre    = 1'b1;
                        pc_src    = branch_taken ? PCSRC_BR : PCSRC_PC4;
                        state_nxt = S_IF;
                    end
                    CLS_LD, CLS_ST: state_nxt = S_MEM;
                    default:        state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                // The write strobe is held for the whole stall so a slow
                // memory sees a stable request.
                dmem_rw = (ins_class == CLS_ST);
                if (mem_ready) begin
                    if (ins_class == CLS_ST) begin
                        pc_wre    = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wre     = 1'b1;
                wr_reg_data = 1'b1;
                pc_wre      = 1'b1;
                state_nxt   = S_IF;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase
    end

    // Reset gates every write strobe so an aborted instruction leaves no trace.
    assign PCWre     = pc_wre  & ~RST;
    assign IRWre     = ir_wre  & ~RST;
    assign RegWre    = reg_wre & ~RST;
    assign DataMemRW = dmem_rw & ~RST;
    assign WrRegData = wr_reg_data;
    assign PCSrc     = pc_src;
    assign InsMemRW  = 1'b1;
    assign halted    = (state == S_HALT);
    assign illegal   = illegal_q;
    assign InsCount  = ins_count;

    // State register, sticky flag and retire counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IF;
            illegal_q <= 1'b0;
            ins_count <= '0;
        end else begin
            state <= state_nxt;
            if (set_illegal) illegal_q <= 1'b1;
            if (pc_wre || enter_halt) ins_count <= ins_count + CNT_W'(1);
        end
    end

endmodule
